// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the synchronous byte FIFO.
package fifo_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  // Pointer width for a given depth; a single bit is kept as the minimum so
  // that the address buses are never zero-width.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] w_words [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] r_word;

    // Each entry loads the write data only when it is the addressed slot.
    always_ff @(posedge clk) begin
      if (i_we && (i_waddr == AW'(gi))) begin
        r_word <= i_wdata;
      end
    end

    assign w_words[gi] = r_word;
  end

  assign o_rdata = w_words[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, registered read data and
// sticky error flags around a small register-array store.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in,
  input  logic                       push,
  input  logic                       pop,
  output logic [WIDTH-1:0]           out,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_out;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_pop_acc;
  logic             w_push_acc;
  logic [WIDTH-1:0] w_rdata;
  logic [CW-1:0]    w_count_next;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when it is paired with a pop.
  assign w_pop_acc  = pop && !w_empty;
  assign w_push_acc = push && (!w_full || w_pop_acc);

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Occupancy moves only when exactly one side is accepted.
  always_comb begin
    w_count_next = r_count;
    case ({w_push_acc, w_pop_acc})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pointer, count, read-data and sticky-flag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_out    <= w_rdata;
      end
      if (push && !w_push_acc) begin
        r_overflow <= 1'b1;
      end
      if (pop && !w_pop_acc) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign out       = r_out;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with hand-computed expectations.
module tb_sync_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] in;
  logic       push;
  logic       pop;
  logic [7:0] out;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int tests_run;
  int tests_failed;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .push      (push),
    .pop       (pop),
    .out       (out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, act);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] d);
    push = 1'b1;
    in   = d;
    tick();
    push = 1'b0;
  endtask

  task automatic do_pop_check(input string tag, input logic [7:0] exp);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check(tag, 32'(out), 32'(exp));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    in    = '0;
    push  = 1'b0;
    pop   = 1'b0;

    // Reset state
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_out",       32'(out), 0);
    check("rst_empty",     32'(empty), 1);
    check("rst_full",      32'(full), 0);
    check("rst_count",     32'(count), 0);
    check("rst_overflow",  32'(overflow), 0);
    check("rst_underflow", 32'(underflow), 0);

    // Fill and drain
    for (int i = 1; i <= 4; i++) do_push(8'(i));
    check("fill_full",  32'(full), 1);
    check("fill_count", 32'(count), 4);
    tick();
    for (int i = 1; i <= 4; i++) do_pop_check($sformatf("drain_%0d", i), 8'(i));
    check("drain_empty", 32'(empty), 1);

    // Overflow
    for (int i = 1; i <= 4; i++) do_push(8'(i));
    do_push(8'd9);
    check("ovf_flag",  32'(overflow), 1);
    check("ovf_count", 32'(count), 4);
    for (int i = 1; i <= 4; i++) do_pop_check($sformatf("ovf_pop_%0d", i), 8'(i));
    check("ovf_empty", 32'(empty), 1);

    // Simultaneous push+pop on empty: only the push lands
    push = 1'b1;
    pop  = 1'b1;
    in   = 8'd8;
    tick();
    push = 1'b0;
    pop  = 1'b0;
    check("unf_flag",  32'(underflow), 1);
    check("unf_count", 32'(count), 1);
    check("unf_out",   32'(out), 4);
    do_pop_check("unf_pop", 8'd8);
    check("unf_count0", 32'(count), 0);

    // Simultaneous push+pop on full, with pointer wrap
    for (int i = 1; i <= 4; i++) do_push(8'(i));
    push = 1'b1;
    pop  = 1'b1;
    in   = 8'd5;
    tick();
    push = 1'b0;
    pop  = 1'b0;
    check("sim_out",   32'(out), 1);
    check("sim_count", 32'(count), 4);
    check("sim_full",  32'(full), 1);
    for (int i = 2; i <= 5; i++) do_pop_check($sformatf("wrap_pop_%0d", i), 8'(i));
    check("wrap_empty", 32'(empty), 1);

    // Async reset between edges
    do_push(8'd1);
    do_push(8'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count",     32'(count), 0);
    check("arst_empty",     32'(empty), 1);
    check("arst_out",       32'(out), 0);
    check("arst_overflow",  32'(overflow), 0);
    check("arst_underflow", 32'(underflow), 0);
    rst_n = 1'b1;
    #1;
    do_push(8'd7);
    check("arst_count1", 32'(count), 1);
    do_pop_check("arst_pop", 8'd7);
    check("arst_empty2", 32'(empty), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
